// File: rtl/scratchram_arbiter_pkg.sv
// Shared types and sizing helpers for the scratch RAM arbiter.
package scratchram_arb_pkg;

  // Arbiter state: waiting for a requester, or owned by one master for its bus cycle
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arbState_e;

  localparam int DW_DEF = 32;
  localparam int SW_DEF = DW_DEF / 8;

  // Width of a master index; a single master still needs one bit
  function automatic int gntWidth(input int nm);
    return (nm > 1) ? $clog2(nm) : 1;
  endfunction

  // Byte-select width for a given data width
  function automatic int selWidth(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/scratchram_arbiter_rr_pick.sv
// Combinational round-robin picker: starting just after the last winner,
// returns the first active request. Wrap-around uses an explicit compare so
// that master counts that are not a power of two rotate correctly.
module rr_pick
  import scratchram_arb_pkg::*;
#(
  parameter int NM = 2,
  parameter int GW = gntWidth(NM)
) (
  input  logic [NM-1:0] req_i,
  input  logic [GW-1:0] last_i,
  output logic          any_o,
  output logic [GW-1:0] idx_o
);

  logic [GW:0] cand;

  // Walk last+1, last+2, ... modulo NM and keep the first requester found
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int off = 1; off <= NM; off++) begin
      cand = {1'b0, last_i} + (GW+1)'(off);
      if (cand >= (GW+1)'(NM)) begin
        cand = cand - (GW+1)'(NM);
      end
      if (!any_o && req_i[cand[GW-1:0]]) begin
        any_o = 1'b1;
        idx_o = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/scratchram_arbiter.sv
// Round-robin arbiter sharing one single-port scratch RAM among NM
// Wishbone-classic masters. A master keeps the RAM for its whole bus cycle
// (cyc held), so bursts and read-modify-write sequences are atomic.
module scratchram_arbiter
  import scratchram_arb_pkg::*;
#(
  parameter int NM = 2,
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NM-1:0]          m_cyc_i,
  input  logic [NM-1:0]          m_stb_i,
  input  logic [NM-1:0]          m_we_i,
  input  logic [NM*(DW/8)-1:0]   m_sel_i,
  input  logic [NM*AW-1:0]       m_adr_i,
  input  logic [NM*DW-1:0]       m_dat_i,
  output logic [NM-1:0]          m_ack_o,
  output logic [DW-1:0]          m_dat_o,
  output logic                   s_cs_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [(DW/8)-1:0]      s_sel_o,
  output logic [AW-1:0]          s_adr_o,
  output logic [DW-1:0]          s_dat_o,
  input  logic                   s_ack_i,
  input  logic [DW-1:0]          s_dat_i
);

  localparam int GW = gntWidth(NM);
  localparam int SW = selWidth(DW);

  arbState_e       state_q, state_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   last_q, last_d;

  logic [NM-1:0]   reqVec;
  logic            pickAny;
  logic [GW-1:0]   pickIdx;

  logic            gntCyc;
  logic            gntStb;
  logic            gntWe;
  logic [SW-1:0]   gntSel;
  logic [AW-1:0]   gntAdr;
  logic [DW-1:0]   gntDat;

  assign reqVec = m_cyc_i & m_stb_i;

  rr_pick #(
    .NM (NM),
    .GW (GW)
  ) u_pick (
    .req_i  (reqVec),
    .last_i (last_q),
    .any_o  (pickAny),
    .idx_o  (pickIdx)
  );

  // Select the fields of whichever master currently holds the grant
  always_comb begin
    gntCyc = 1'b0;
    gntStb = 1'b0;
    gntWe  = 1'b0;
    gntSel = '0;
    gntAdr = '0;
    gntDat = '0;
    for (int k = 0; k < NM; k++) begin
      if (gnt_q == GW'(k)) begin
        gntCyc = m_cyc_i[k];
        gntStb = m_stb_i[k];
        gntWe  = m_we_i[k];
        gntSel = m_sel_i[k*SW +: SW];
        gntAdr = m_adr_i[k*AW +: AW];
        gntDat = m_dat_i[k*DW +: DW];
      end
    end
  end

  // Next state: grant on any request from IDLE; release (with one dead cycle) when cyc drops
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pickAny) begin
          gnt_d   = pickIdx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!gntCyc) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers; reset makes master 0 win first
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= GW'(NM - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Route the granted master to the RAM and steer ack back to it alone; quiet bus while idle
  always_comb begin
    s_cs_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    if (state_q == ST_BUSY) begin
      s_cs_o  = gntCyc;
      s_cyc_o = gntCyc;
      s_stb_o = gntStb;
      s_we_o  = gntWe;
      s_sel_o = gntSel;
      s_adr_o = gntAdr;
      s_dat_o = gntDat;
      for (int k = 0; k < NM; k++) begin
        m_ack_o[k] = (gnt_q == GW'(k)) & s_ack_i & gntCyc & gntStb;
      end
    end
  end

  assign m_dat_o = s_dat_i;

endmodule
